clock_tree: RTL and testbench



---
 rtl/clock_tree_if.sv | 30 +++
 rtl/clock_tree.sv | 76 +++++++
 tb/tb_clock_tree.sv | 176 +++++++++++++++++
 3 files changed

// File: rtl/clock_tree_if.sv
// Phase-clock bundle of clock_tree: the level and strobe outputs plus phase index.
// Stall exists only when CLOCK_TREE_STALL_EN is defined.
interface clock_tree_if;
  logic       ClockPc;
  logic       ClockWrRd;
  logic       PcRise;
  logic       WrRdRise;
  logic [3:0] Phase;
`ifdef CLOCK_TREE_STALL_EN
  logic       Stall;

  modport master (
    output ClockPc, ClockWrRd, PcRise, WrRdRise, Phase,
    input  Stall
  );

  modport slave (
    input  ClockPc, ClockWrRd, PcRise, WrRdRise, Phase,
    output Stall
  );
`else
  modport master (
    output ClockPc, ClockWrRd, PcRise, WrRdRise, Phase
  );

  modport slave (
    input  ClockPc, ClockWrRd, PcRise, WrRdRise, Phase
  );
`endif
endinterface

// File: rtl/clock_tree.sv
// Phase-clock generator: PHASES-cycle counter driving two registered 50%-duty enables.
// Optional macro CLOCK_TREE_STALL_EN adds a Stall input that freezes the sequence.
module clock_tree #(
  parameter int PHASES      = 4,
  parameter int WRRD_OFFSET = 1
) (
  input  logic          Clock,
  input  logic          Reset,
  clock_tree_if.master  bus
);

  if (PHASES < 2 || PHASES > 16 || (PHASES % 2) != 0 ||
      WRRD_OFFSET < 0 || WRRD_OFFSET >= PHASES) begin : g_bad_params
    $fatal(1, "clock_tree: illegal PHASES=%0d / WRRD_OFFSET=%0d", PHASES, WRRD_OFFSET);
  end

  localparam logic [3:0] LP_LAST  = 4'(PHASES - 1);
  localparam logic [4:0] LP_NPH   = 5'(PHASES);
  localparam logic [4:0] LP_HALF  = 5'(PHASES / 2);
  localparam logic [4:0] LP_SHIFT = 5'(PHASES - WRRD_OFFSET);

  logic [3:0] r_phase;
  logic       r_clk_pc;
  logic       r_clk_wrrd;
  logic       r_pc_rise;
  logic       r_wrrd_rise;

  logic [3:0] w_phase_next;
  logic [4:0] w_wrrd_sum;
  logic [4:0] w_wrrd_idx;
  logic       w_pc_next;
  logic       w_wrrd_next;
  logic       w_stall;

`ifdef CLOCK_TREE_STALL_EN
  assign w_stall = bus.Stall;
`else
  assign w_stall = 1'b0;
`endif

  // Levels decode the next phase so they line up with the registered Phase.
  // The sum is below 2*PHASES, so a single conditional subtract is the modulo.
  always_comb begin
    w_phase_next = (r_phase == LP_LAST) ? 4'd0 : r_phase + 4'd1;
    w_wrrd_sum   = {1'b0, w_phase_next} + LP_SHIFT;
    w_wrrd_idx   = (w_wrrd_sum >= LP_NPH) ? w_wrrd_sum - LP_NPH : w_wrrd_sum;
    w_pc_next    = ({1'b0, w_phase_next} < LP_HALF);
    w_wrrd_next  = (w_wrrd_idx < LP_HALF);
  end

  always_ff @(posedge Clock) begin
    if (Reset) begin
      r_phase     <= 4'd0;
      r_clk_pc    <= 1'b0;
      r_clk_wrrd  <= 1'b0;
      r_pc_rise   <= 1'b0;
      r_wrrd_rise <= 1'b0;
    end else if (w_stall) begin
      r_pc_rise   <= 1'b0;
      r_wrrd_rise <= 1'b0;
    end else begin
      r_phase     <= w_phase_next;
      r_clk_pc    <= w_pc_next;
      r_clk_wrrd  <= w_wrrd_next;
      r_pc_rise   <= w_pc_next & ~r_clk_pc;
      r_wrrd_rise <= w_wrrd_next & ~r_clk_wrrd;
    end
  end

  assign bus.Phase     = r_phase;
  assign bus.ClockPc   = r_clk_pc;
  assign bus.ClockWrRd = r_clk_wrrd;
  assign bus.PcRise    = r_pc_rise;
  assign bus.WrRdRise  = r_wrrd_rise;

endmodule

// File: tb/tb_clock_tree.sv
// Directed bench for clock_tree: defaults instance plus a PHASES=8/WRRD_OFFSET=3 instance.
`timescale 1ns/1ps
module tb_clock_tree;
  logic Clock = 1'b0;
  logic Reset = 1'b1;
  int   n_checks = 0;
  int   n_errors = 0;

  clock_tree_if bus  ();
  clock_tree_if bus8 ();

  clock_tree #(.PHASES(4), .WRRD_OFFSET(1)) dut  (.Clock(Clock), .Reset(Reset), .bus(bus));
  clock_tree #(.PHASES(8), .WRRD_OFFSET(3)) dut8 (.Clock(Clock), .Reset(Reset), .bus(bus8));

  always #5 Clock = ~Clock;

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout, expected end of test");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end else begin
      $display("ok   %s: %0d at %0t", tag, got, $time);
    end
  endtask

  task automatic tick();
    @(posedge Clock);
    #1;
  endtask

  // Expected values for edges 1..8 after reset release, defaults.
  logic [3:0] exp_ph  [8] = '{4'd1, 4'd2, 4'd3, 4'd0, 4'd1, 4'd2, 4'd3, 4'd0};
  logic       exp_pc  [8] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
  logic       exp_wr  [8] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
  logic       exp_pcr [8] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
  logic       exp_wrr [8] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};

  initial begin
    longint t, pc_rise_t, wr_rise_t, pc8_rise_t;
    logic   prev_pc, prev_wr, prev_pcr, prev_wrr, prev_pc8, prev_wr8;
    int     pc_rises, wr_rises, pc8_high, wr8_high;
    bit     found;

`ifdef CLOCK_TREE_STALL_EN
    bus.Stall  = 1'b0;
    bus8.Stall = 1'b0;
`endif
    Reset = 1'b1;
    tick();
    tick();
    check("rst_phase", bus.Phase, 0);
    check("rst_pc", bus.ClockPc, 0);
    check("rst_wrrd", bus.ClockWrRd, 0);
    check("rst_pcrise", bus.PcRise, 0);
    check("rst_wrrise", bus.WrRdRise, 0);
    check("rst_pc8", bus8.ClockPc, 0);

    Reset = 1'b0;
    for (int e = 0; e < 8; e++) begin
      tick();
      $display("edge %0d: Phase=%0d Pc=%0b WrRd=%0b PcRise=%0b WrRdRise=%0b",
               e + 1, bus.Phase, bus.ClockPc, bus.ClockWrRd, bus.PcRise, bus.WrRdRise);
      check($sformatf("e%0d_phase", e + 1), bus.Phase, exp_ph[e]);
      check($sformatf("e%0d_pc", e + 1), bus.ClockPc, exp_pc[e]);
      check($sformatf("e%0d_wrrd", e + 1), bus.ClockWrRd, exp_wr[e]);
      check($sformatf("e%0d_pcrise", e + 1), bus.PcRise, exp_pcr[e]);
      check($sformatf("e%0d_wrrise", e + 1), bus.WrRdRise, exp_wrr[e]);
      if (e == 2) begin
        // PHASES=8, offset 3: WrRd high for next phase 3..6, so it first rises at edge 3.
        check("e3_p8_wrrd", bus8.ClockWrRd, 1);
        check("e3_p8_wrrise", bus8.WrRdRise, 1);
        check("e3_p8_pc", bus8.ClockPc, 1);
      end
    end

    // Free-run: period/high time of both outputs, strobe shape, PHASES=8 lag and duty.
    pc_rise_t = -1; wr_rise_t = -1; pc8_rise_t = -1;
    prev_pc = bus.ClockPc; prev_wr = bus.ClockWrRd;
    prev_pcr = bus.PcRise; prev_wrr = bus.WrRdRise;
    prev_pc8 = bus8.ClockPc; prev_wr8 = bus8.ClockWrRd;
    pc_rises = 0; wr_rises = 0; pc8_high = 0; wr8_high = 0;
    for (int i = 0; i < 1000; i++) begin
      tick();
      t = $time;
      if (bus.ClockPc && !prev_pc) begin
        pc_rises++;
        if (pc_rise_t >= 0) check("pc_period_ns", 32'(t - pc_rise_t), 40);
        pc_rise_t = t;
      end
      if (!bus.ClockPc && prev_pc && pc_rise_t >= 0) check("pc_high_ns", 32'(t - pc_rise_t), 20);
      if (bus.ClockWrRd && !prev_wr) begin
        wr_rises++;
        if (wr_rise_t >= 0) check("wr_period_ns", 32'(t - wr_rise_t), 40);
        wr_rise_t = t;
      end
      if (!bus.ClockWrRd && prev_wr && wr_rise_t >= 0) check("wr_high_ns", 32'(t - wr_rise_t), 20);
      check("pcrise_shape", bus.PcRise, bus.ClockPc & ~prev_pc);
      check("wrrise_shape", bus.WrRdRise, bus.ClockWrRd & ~prev_wr);
      if (prev_pcr) check("pcrise_single", bus.PcRise, 0);
      if (prev_wrr) check("wrrise_single", bus.WrRdRise, 0);

      if (bus8.ClockPc && !prev_pc8) begin
        if (pc8_rise_t >= 0) check("p8_pc_period_ns", 32'(t - pc8_rise_t), 80);
        pc8_rise_t = t;
      end
      if (bus8.ClockWrRd && !prev_wr8 && pc8_rise_t >= 0)
        check("p8_wr_lag_ns", 32'(t - pc8_rise_t), 30);
      if (bus8.ClockPc) pc8_high++;
      if (bus8.ClockWrRd) wr8_high++;

      prev_pc = bus.ClockPc; prev_wr = bus.ClockWrRd;
      prev_pcr = bus.PcRise; prev_wrr = bus.WrRdRise;
      prev_pc8 = bus8.ClockPc; prev_wr8 = bus8.ClockWrRd;
    end
    check("pc_rise_count", pc_rises, 250);
    check("wr_rise_count", wr_rises, 250);
    check("p8_pc_high_cycles", pc8_high, 500);
    check("p8_wr_high_cycles", wr8_high, 500);

    // Reset mid-cycle at Phase=2.
    found = 1'b0;
    for (int k = 0; k < 8 && !found; k++) begin
      if (bus.Phase == 4'd2) found = 1'b1;
      else tick();
    end
    check("wait_phase2", found, 1);
    Reset = 1'b1;
    tick();
    check("mid_rst_phase", bus.Phase, 0);
    check("mid_rst_pc", bus.ClockPc, 0);
    check("mid_rst_wrrd", bus.ClockWrRd, 0);
    check("mid_rst_pcrise", bus.PcRise, 0);
    check("mid_rst_wrrise", bus.WrRdRise, 0);
    Reset = 1'b0;
    tick();
    check("post_rst_phase", bus.Phase, 1);
    check("post_rst_pc", bus.ClockPc, 1);
    check("post_rst_pcrise", bus.PcRise, 1);

`ifdef CLOCK_TREE_STALL_EN
    found = 1'b0;
    for (int k = 0; k < 8 && !found; k++) begin
      if (bus.Phase == 4'd3) found = 1'b1;
      else tick();
    end
    check("wait_phase3", found, 1);
    bus.Stall  = 1'b1;
    bus8.Stall = 1'b1;
    for (int k = 0; k < 5; k++) begin
      tick();
      check("stall_phase", bus.Phase, 3);
      check("stall_pc", bus.ClockPc, 0);
      check("stall_wrrd", bus.ClockWrRd, 0);
      check("stall_pcrise", bus.PcRise, 0);
      check("stall_wrrise", bus.WrRdRise, 0);
    end
    bus.Stall  = 1'b0;
    bus8.Stall = 1'b0;
    tick();
    check("unstall_phase", bus.Phase, 0);
    check("unstall_pc", bus.ClockPc, 1);
    check("unstall_pcrise", bus.PcRise, 1);
    check("unstall_wrrise", bus.WrRdRise, 0);
`endif

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule
